// File: rtl/parity_step_counter.sv
// parity_step_counter: up/down counter that walks through odd or even values.
// Each enabled step moves to the next value of the selected parity in the
// direction of travel: +/-2 when already aligned, +/-1 to realign. Synchronous
// load and synchronous active-high reset. tc flags a step that crossed the
// 2^WIDTH boundary.
// Build option: define PSC_SATURATE_EN to clamp at the parity extremes
// instead of wrapping (tc then marks every clamped step).
module parity_step_counter #(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ud,
    input  logic             oe,
    output logic [WIDTH-1:0] out,
    output logic             tc
);

    localparam logic [WIDTH:0] STEP_ONE = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] STEP_TWO = {{(WIDTH-1){1'b0}}, 2'b10};

`ifdef PSC_SATURATE_EN
    localparam logic [WIDTH-1:0] MAX_ODD  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MAX_EVEN = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0] MIN_ODD  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_EVEN = {WIDTH{1'b0}};
`endif

    // Step size: 2 keeps an aligned value on its parity, 1 realigns it.
    function automatic logic [WIDTH:0] step_size(input logic lsb, input logic odd_sel);
        logic [WIDTH:0] s;
        if (lsb == odd_sel) begin
            s = STEP_TWO;
        end else begin
            s = STEP_ONE;
        end
        return s;
    endfunction

    logic [WIDTH-1:0] out_r;
    logic             tc_r;
    logic [WIDTH-1:0] out_next_s;
    logic             tc_next_s;
    logic [WIDTH:0]   step_s;
    logic [WIDTH:0]   up_sum_s;
    logic [WIDTH:0]   dn_diff_s;
    logic [WIDTH-1:0] raw_s;
    logic             wrap_s;

    assign out = out_r;
    assign tc  = tc_r;

    // Candidate step in both directions; the extra MSB is carry / borrow.
    always_comb begin
        step_s    = step_size(out_r[0], oe);
        up_sum_s  = {1'b0, out_r} + step_s;
        dn_diff_s = {1'b0, out_r} - step_s;
        if (ud) begin
            raw_s  = up_sum_s[WIDTH-1:0];
            wrap_s = up_sum_s[WIDTH];
        end else begin
            raw_s  = dn_diff_s[WIDTH-1:0];
            wrap_s = dn_diff_s[WIDTH];
        end
    end

    // Next-state selection with priority load > en > hold (reset in the register).
    always_comb begin
        out_next_s = out_r;
        tc_next_s  = 1'b0;
        if (load) begin
            out_next_s = load_val;
            tc_next_s  = 1'b0;
        end else if (en) begin
`ifdef PSC_SATURATE_EN
            if (wrap_s) begin
                case ({ud, oe})
                    2'b11:   out_next_s = MAX_ODD;
                    2'b10:   out_next_s = MAX_EVEN;
                    2'b01:   out_next_s = MIN_ODD;
                    2'b00:   out_next_s = MIN_EVEN;
                    default: out_next_s = MIN_EVEN;
                endcase
            end else begin
                out_next_s = raw_s;
            end
`else
            out_next_s = raw_s;
`endif
            tc_next_s = wrap_s;
        end else begin
            out_next_s = out_r;
            tc_next_s  = 1'b0;
        end
    end

    // Output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r <= RST_VAL;
            tc_r  <= 1'b0;
        end else begin
            out_r <= out_next_s;
            tc_r  <= tc_next_s;
        end
    end

endmodule

// File: tb/tb_parity_step_counter.sv
// Testbench for parity_step_counter (WIDTH=4, RST_VAL=0): directed vector
// table for the boundary/priority cases, then random stimulus against a
// reference model that searches for the next value of the selected parity.
module tb_parity_step_counter;

    localparam int W = 4;
    localparam int M = 16;

    logic         clk = 1'b0;
    logic         rst, en, load, ud, oe;
    logic [W-1:0] load_val;
    logic [W-1:0] dut_out;
    logic         dut_tc;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic         rst;
        logic         load;
        logic [W-1:0] load_val;
        logic         en;
        logic         ud;
        logic         oe;
        logic [W-1:0] exp_out;
        logic         exp_tc;
        string        name;
    } vec_t;

    vec_t vecs[$];

    int m_out;
    bit m_tc;

    parity_step_counter #(.WIDTH(W), .RST_VAL(4'd0)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .ud       (ud),
        .oe       (oe),
        .out      (dut_out),
        .tc       (dut_tc)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic add(input string nm, input bit r, input bit l, input int lv,
                       input bit e, input bit u, input bit o, input int eo, input bit et);
        vec_t v;
        v.name = nm; v.rst = r; v.load = l; v.load_val = lv[W-1:0];
        v.en = e; v.ud = u; v.oe = o; v.exp_out = eo[W-1:0]; v.exp_tc = et;
        vecs.push_back(v);
    endtask

    task automatic drive_and_check(input string nm, input bit r, input bit l, input logic [W-1:0] lv,
                                   input bit e, input bit u, input bit o,
                                   input logic [W-1:0] eo, input bit et);
        rst = r; load = l; load_val = lv; en = e; ud = u; oe = o;
        @(posedge clk);
        #1;
        n_vec++;
        if (dut_out !== eo || dut_tc !== et) begin
            n_fail++;
            $display("FAIL %s: got out=%0d tc=%0b, expected out=%0d tc=%0b",
                     nm, dut_out, dut_tc, eo, et);
        end
    endtask

    // Reference: next value of the requested parity strictly beyond the current one.
    task automatic model_step(input bit r, input bit l, input int lv,
                              input bit e, input bit u, input bit o);
        int  n;
        bit  beyond;
        if (r) begin
            m_out = 0; m_tc = 1'b0;
        end else if (l) begin
            m_out = lv; m_tc = 1'b0;
        end else if (e) begin
            if (u) begin
                n = m_out + 1;
                if ((n & 1) != int'(o)) n = n + 1;
                beyond = (n >= M);
            end else begin
                n = m_out - 1;
                if ((n & 1) != int'(o)) n = n - 1;
                beyond = (n < 0);
            end
            if (beyond) begin
`ifdef PSC_SATURATE_EN
                if (u) n = o ? M - 1 : M - 2;
                else   n = o ? 1 : 0;
`else
                n = (n + M) % M;
`endif
            end
            m_out = n;
            m_tc  = beyond;
        end else begin
            m_tc = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; ud = 1'b0; oe = 1'b0; load_val = 4'd0;

        // Reset state
        add("reset", 1, 0, 0, 0, 0, 0, 0, 0);
        // Up-odd walk and wrap
        for (int v = 1; v <= 15; v += 2) add("up_odd", 0, 0, 0, 1, 1, 1, v, 0);
`ifdef PSC_SATURATE_EN
        add("up_odd_clamp", 0, 0, 0, 1, 1, 1, 15, 1);
        add("up_odd_clamp2", 0, 0, 0, 1, 1, 1, 15, 1);
`else
        add("up_odd_wrap", 0, 0, 0, 1, 1, 1, 1, 1);
        add("up_odd_after", 0, 0, 0, 1, 1, 1, 3, 0);
`endif
        add("hold_clears_tc", 0, 0, 0, 0, 1, 1, 15 - 14 * 0 - (`ifdef PSC_SATURATE_EN 0 `else 12 `endif), 0);
        // Down-even from 7
        add("load7", 0, 1, 7, 0, 0, 0, 7, 0);
        add("dn_even", 0, 0, 0, 1, 0, 0, 6, 0);
        add("dn_even", 0, 0, 0, 1, 0, 0, 4, 0);
        add("dn_even", 0, 0, 0, 1, 0, 0, 2, 0);
        add("dn_even", 0, 0, 0, 1, 0, 0, 0, 0);
`ifdef PSC_SATURATE_EN
        add("dn_even_clamp", 0, 0, 0, 1, 0, 0, 0, 1);
        add("dn_even_clamp2", 0, 0, 0, 1, 0, 0, 0, 1);
`else
        add("dn_even_wrap", 0, 0, 0, 1, 0, 0, 14, 1);
        add("dn_even_after", 0, 0, 0, 1, 0, 0, 12, 0);
`endif
        // Mode switch up-even to up-odd with no dead cycle
        add("rst2", 1, 0, 0, 1, 1, 0, 0, 0);
        add("up_even", 0, 0, 0, 1, 1, 0, 2, 0);
        add("up_even", 0, 0, 0, 1, 1, 0, 4, 0);
        add("up_even", 0, 0, 0, 1, 1, 0, 6, 0);
        add("switch_odd", 0, 0, 0, 1, 1, 1, 7, 0);
        add("switch_odd2", 0, 0, 0, 1, 1, 1, 9, 0);
        // Priority
        add("load_over_en", 0, 1, 9, 1, 1, 1, 9, 0);
        add("rst_over_load", 1, 1, 9, 1, 1, 1, 0, 0);
        add("load5", 0, 1, 5, 0, 0, 0, 5, 0);
        for (int i = 0; i < 3; i++) add("hold", 0, 0, 3, 0, 1, 1, 5, 0);
        // Misaligned boundary, down-odd from 0
        add("load0", 0, 1, 0, 0, 0, 1, 0, 0);
`ifdef PSC_SATURATE_EN
        add("misalign_clamp", 0, 0, 0, 1, 0, 1, 1, 1);
        add("misalign_clamp2", 0, 0, 0, 1, 0, 1, 1, 1);
`else
        add("misalign_wrap", 0, 0, 0, 1, 0, 1, 15, 1);
        add("misalign_after", 0, 0, 0, 1, 0, 1, 13, 0);
`endif
        add("load_after_tc", 0, 1, 9, 1, 0, 1, 9, 0);
        // Reset mid-operation
        add("up_odd_11", 0, 0, 0, 1, 1, 1, 11, 0);
        add("rst_mid", 1, 0, 0, 1, 1, 1, 0, 0);
        add("resume1", 0, 0, 0, 1, 1, 1, 1, 0);
        add("resume3", 0, 0, 0, 1, 1, 1, 3, 0);

        foreach (vecs[i])
            drive_and_check(vecs[i].name, vecs[i].rst, vecs[i].load, vecs[i].load_val,
                            vecs[i].en, vecs[i].ud, vecs[i].oe, vecs[i].exp_out, vecs[i].exp_tc);

        // Random phase against the reference model
        for (int i = 0; i < 3000; i++) begin
            bit r, l, e, u, o;
            int lv;
            r  = (i == 0) || ($urandom_range(0, 63) == 0);
            l  = ($urandom_range(0, 11) == 0);
            lv = int'($urandom_range(0, M - 1));
            e  = ($urandom_range(0, 4) != 0);
            u  = ($urandom_range(0, 7) != 0) ? ((i / 40) % 2 == 0) : $urandom_range(0, 1) == 1;
            o  = ($urandom_range(0, 5) == 0) ? ~((i / 25) % 2 == 1) : ((i / 25) % 2 == 1);
            model_step(r, l, lv, e, u, o);
            drive_and_check("random", r, l, lv[W-1:0], e, u, o, m_out[W-1:0], m_tc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_step_counter.md
PARITY_STEP_COUNTER -- requirements
Module: parity_step_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, counter width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter RST_VAL, default 0, value loaded into out on reset (WIDTH bits).
REQ-003 Port clk SHALL be input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst SHALL be input, 1 bit; reset is synchronous and active-high.
REQ-005 Port en SHALL be input, 1 bit, count enable; step one position per cycle while high.
REQ-006 Port load SHALL be input, 1 bit, synchronous load strobe.
REQ-007 Port load_val SHALL be input, WIDTH bits, value captured when load is high.
REQ-008 Port ud SHALL be input, 1 bit, direction; 1 = up, 0 = down.
REQ-009 Port oe SHALL be input, 1 bit, parity select; 1 = odd sequence, 0 = even sequence.
REQ-010 Port out SHALL be output, WIDTH bits, registered count value.
REQ-011 Port tc SHALL be output, 1 bit, registered terminal-count flag.

Function
REQ-012 Per-cycle priority SHALL be rst > load > en > hold.
REQ-013 On load, out SHALL take load_val unmodified; tc SHALL be 0; no step occurs that cycle, even if en is high.
REQ-014 With en low and load low, out SHALL hold and tc SHALL be 0.
REQ-015 Aligned step: if en high and out[0] == oe, out SHALL become out+2 (ud=1) or out-2 (ud=0).
REQ-016 Misaligned step: if en high and out[0] != oe, out SHALL become out+1 (ud=1) or out-1 (ud=0); this realigns to the selected parity in the direction of travel.
REQ-017 ud and oe SHALL be sampled every cycle; a change takes effect on the next enabled step, with no dead cycle.
REQ-018 Arithmetic SHALL be modulo 2^WIDTH; an out-of-range result wraps.
REQ-019 tc SHALL be 1 for exactly the cycle in which out holds a value produced by a wrapping step (carry on up, borrow on down); otherwise tc SHALL be 0.
REQ-020 Latency SHALL be one cycle from the sampled inputs to out/tc.

Reset
REQ-021 While rst is high at a rising edge, out SHALL become RST_VAL and tc SHALL become 0, regardless of en, load or mode inputs.
REQ-022 Reset asserted mid-sequence SHALL discard any in-progress step; counting resumes from RST_VAL on the first enabled cycle after rst falls.

Configuration
REQ-023 Macro PSC_SATURATE_EN SHALL select boundary behaviour.
REQ-024 Without PSC_SATURATE_EN, boundaries SHALL wrap per REQ-018/REQ-019.
REQ-025 With PSC_SATURATE_EN, a step that would wrap SHALL instead set out to the extreme value of the selected parity: up-odd 2^WIDTH-1, up-even 2^WIDTH-2, down-even 0, down-odd 1.
REQ-026 With PSC_SATURATE_EN, tc SHALL be 1 on every enabled, non-load cycle in which a step was clamped.
REQ-027 With PSC_SATURATE_EN, tc SHALL be 0 on a non-clamped step.

Verification (WIDTH=4, RST_VAL=0)
REQ-028 Up-odd wrap: rst, then en=1 ud=1 oe=1. out SHALL be 1,3,5,...,15,1. tc SHALL be 1 only with the second 1. Saturate build: out holds 15 with tc=1 each cycle.
REQ-029 Down-even wrap: load 7, then en=1 ud=0 oe=0. out SHALL be 6,4,2,0,14. tc SHALL be 1 only with 14. Saturate build: out holds 0 with tc=1.
REQ-030 Mode switch: count up-even to 6, then set oe=1 for the next step. out SHALL be 7, then 9, with no hold cycle.
REQ-031 Priority: load=1 with load_val=9 and en=1 gives out=9, tc=0. rst=1 with load=1 gives out=0. en=0 holds out for 3 cycles.
REQ-032 Misaligned boundary: load 0, ud=0 oe=1, en=1. Wrap build: out SHALL be 15 with tc=1. Saturate build: out SHALL be 1 with tc=1.
REQ-033 Reset mid-operation: at out=11 counting up-odd, pulse rst for 1 cycle. out SHALL be 0, then 1, 3 on the following enabled cycles.
